// File: rtl/ac_pkg.sv
// Shared definitions for the analog-comparator digital controller:
// register map, FSM states, edge-select encoding and field positions.
package ac_pkg;

    localparam logic [1:0] AC_CTRL   = 2'd0;
    localparam logic [1:0] AC_STATUS = 2'd1;
    localparam logic [1:0] AC_FILT   = 2'd2;

    typedef enum logic [1:0] {
        AC_OFF,
        AC_SETTLE,
        AC_RUN
    } ac_state_t;

    typedef enum logic [1:0] {
        AC_IS_TOG0 = 2'b00,
        AC_IS_TOG1 = 2'b01,
        AC_IS_FALL = 2'b10,
        AC_IS_RISE = 2'b11
    } ac_isel_t;

    localparam int CTRL_ACEN     = 0;
    localparam int CTRL_ACIS_LSB = 1;
    localparam int CTRL_ACIS_MSB = 2;
    localparam int CTRL_ACIE     = 3;

    localparam int STAT_ACO   = 0;
    localparam int STAT_ACI   = 1;
    localparam int STAT_READY = 2;

    // Whether a change away from old_v counts as an interrupting edge.
    function automatic logic edge_hit(input ac_isel_t isel, input logic old_v);
        logic hit;
        case (isel)
            AC_IS_FALL: hit = old_v;
            AC_IS_RISE: hit = ~old_v;
            default:    hit = 1'b1;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ac_filt.sv
// Comparator input conditioning: two-flop synchroniser followed by a
// run-length glitch filter that drives the filtered comparator value.
module ac_filt
    import ac_pkg::*;
#(
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              load,
    input  logic [FILT_W-1:0] n,
    input  logic              din,
    output logic              dout,
    output logic              upd
);

    logic              s1_q, s2_q;
    logic              aco_q, aco_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            aco_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= din;
            s2_q  <= s1_q;
            aco_q <= aco_d;
            cnt_q <= cnt_d;
        end
    end

    // aco only follows s2 after it has disagreed for n+1 consecutive compares.
    always_comb begin
        aco_d = aco_q;
        cnt_d = cnt_q;
        upd   = 1'b0;
        if (load) begin
            aco_d = s2_q;
            cnt_d = '0;
        end else if (run) begin
            if (s2_q == aco_q) begin
                cnt_d = '0;
            end else if (cnt_q == n) begin
                aco_d = s2_q;
                cnt_d = '0;
                upd   = 1'b1;
            end else begin
                cnt_d = cnt_q + FILT_W'(1);
            end
        end
    end

    assign dout = aco_q;

endmodule

// File: rtl/ac_dig.sv
// Analog comparator controller: enable/settle sequencing, register file,
// edge detection and sticky interrupt flag on top of the input filter.
module ac_dig
    import ac_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int FILT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       acout,
    output logic       acenable,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic [7:0] rdata,
    output logic       aco,
    output logic       irq
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    ac_state_t         state_q, state_d;
    logic [7:0]        settle_q, settle_d;
    logic              acen_q, acen_d;
    ac_isel_t          acis_q, acis_d;
    logic              acie_q, acie_d;
    logic              aci_q, aci_d;
    logic [FILT_W-1:0] filt_q, filt_d;

    logic              load;
    logic              run;
    logic              upd;
    logic              edge_set;
    logic              wr_ctrl, wr_status, wr_filt;
    logic [7:0]        status;
    logic              unused_wdata;

    assign unused_wdata = ^wdata[7:4];

    assign wr_ctrl   = we && (addr == AC_CTRL);
    assign wr_status = we && (addr == AC_STATUS);
    assign wr_filt   = we && (addr == AC_FILT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= AC_OFF;
            settle_q <= '0;
            acen_q   <= 1'b0;
            acis_q   <= AC_IS_TOG0;
            acie_q   <= 1'b0;
            aci_q    <= 1'b0;
            filt_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            acen_q   <= acen_d;
            acis_q   <= acis_d;
            acie_q   <= acie_d;
            aci_q    <= aci_d;
            filt_q   <= filt_d;
        end
    end

    // Every enable goes through a full settle; load fires on the SETTLE->RUN step.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        load     = 1'b0;
        case (state_q)
            AC_OFF: begin
                settle_d = '0;
                if (acen_q) begin
                    state_d  = AC_SETTLE;
                    settle_d = SETTLE_LOAD;
                end
            end
            AC_SETTLE: begin
                if (!acen_q) begin
                    state_d  = AC_OFF;
                    settle_d = '0;
                end else if (settle_q == 8'd0) begin
                    state_d = AC_RUN;
                    load    = 1'b1;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            AC_RUN: begin
                if (!acen_q) begin
                    state_d = AC_OFF;
                end
            end
            default: begin
                state_d  = AC_OFF;
                settle_d = '0;
            end
        endcase
    end

    assign run      = (state_q == AC_RUN);
    assign acenable = acen_q && (state_q != AC_OFF);

    ac_filt #(
        .FILT_W (FILT_W)
    ) u_filt (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .load (load),
        .n    (filt_q),
        .din  (acout),
        .dout (aco),
        .upd  (upd)
    );

    assign edge_set = upd && edge_hit(acis_q, aco);

    always_comb begin
        acen_d = acen_q;
        acis_d = acis_q;
        acie_d = acie_q;
        filt_d = filt_q;
        aci_d  = aci_q;
        if (wr_ctrl) begin
            acen_d = wdata[CTRL_ACEN];
            acis_d = ac_isel_t'(wdata[CTRL_ACIS_MSB:CTRL_ACIS_LSB]);
            acie_d = wdata[CTRL_ACIE];
        end
        if (wr_filt) begin
            filt_d = wdata[FILT_W-1:0];
        end
        // A same-cycle set beats the write-1-to-clear.
        if (edge_set) begin
            aci_d = 1'b1;
        end else if (wr_status && wdata[STAT_ACI]) begin
            aci_d = 1'b0;
        end
    end

    assign irq = aci_q && acie_q;

    always_comb begin
        status             = '0;
        status[STAT_ACO]   = aco;
        status[STAT_ACI]   = aci_q;
        status[STAT_READY] = run;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            AC_CTRL: begin
                rdata[CTRL_ACEN]                    = acen_q;
                rdata[CTRL_ACIS_MSB:CTRL_ACIS_LSB]  = acis_q;
                rdata[CTRL_ACIE]                    = acie_q;
            end
            AC_STATUS: rdata = status;
            AC_FILT:   rdata = 8'(filt_q);
            default:   rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ac_dig.sv
// Directed bench for ac_dig with a cycle-level behavioural reference model.
module tb_ac_dig;

    localparam int SETTLE_CYC = 16;
    localparam int FILT_W     = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       acout = 1'b0;
    logic       acenable;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'd0;
    logic       we = 1'b0;
    logic [7:0] rdata;
    logic       aco;
    logic       irq;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    ac_dig #(.SETTLE_CYC(SETTLE_CYC), .FILT_W(FILT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .acout    (acout),
        .acenable (acenable),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .aco      (aco),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: enable age, synchroniser delay line, mismatch streak.
    bit m_on, m_acen, m_acie, m_aci, m_aco, m_s1, m_s2;
    logic [1:0] m_acis;
    int m_age, m_filt, m_streak;

    function automatic bit qualifies(input logic [1:0] isel, input bit new_v);
        if (isel == 2'b11) return new_v == 1'b1;
        if (isel == 2'b10) return new_v == 1'b0;
        return 1'b1;
    endfunction

    always begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_on = 0; m_acen = 0; m_acie = 0; m_aci = 0; m_aco = 0;
            m_s1 = 0; m_s2 = 0; m_acis = 2'b00; m_age = 0; m_filt = 0; m_streak = 0;
        end else begin
            bit s2p, set;
            s2p = m_s2;
            set = 0;
            if (m_on) begin
                if (m_age >= SETTLE_CYC) begin
                    if (s2p != m_aco) begin
                        m_streak++;
                        if (m_streak >= m_filt + 1) begin
                            set = qualifies(m_acis, s2p);
                            m_aco = s2p;
                            m_streak = 0;
                        end
                    end else begin
                        m_streak = 0;
                    end
                end else if (m_age == SETTLE_CYC - 1 && m_acen) begin
                    m_aco = s2p;
                    m_streak = 0;
                end
                if (!m_acen) begin
                    m_on = 0;
                    m_age = 0;
                end else if (m_age < SETTLE_CYC) begin
                    m_age++;
                end
            end else if (m_acen) begin
                m_on = 1;
                m_age = 0;
            end
            if (we) begin
                case (addr)
                    2'd0: begin m_acen = wdata[0]; m_acis = wdata[2:1]; m_acie = wdata[3]; end
                    2'd1: if (wdata[1]) m_aci = 0;
                    2'd2: m_filt = int'(wdata[3:0]);
                    default: ;
                endcase
            end
            if (set) m_aci = 1;
            m_s2 = m_s1;
            m_s1 = acout;
        end
    end

    function automatic logic [7:0] model_rdata(input logic [1:0] a);
        logic [7:0] r;
        r = 8'd0;
        case (a)
            2'd0: r = {4'd0, m_acie, m_acis, m_acen};
            2'd1: r = {5'd0, (m_on && m_age >= SETTLE_CYC), m_aci, m_aco};
            2'd2: r = 8'(m_filt);
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_acenable", {7'd0, acenable}, {7'd0, (m_on && m_acen)});
            check("cmp_aco", {7'd0, aco}, {7'd0, m_aco});
            check("cmp_irq", {7'd0, irq}, {7'd0, (m_aci && m_acie)});
            check("cmp_rdata", rdata, model_rdata(addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0; wdata = 8'd0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic count_settle(input string name);
        int cnt;
        cnt = 0;
        addr = 2'd1;
        #1;
        while (!rdata[2] && cnt < 40) begin
            tick();
            cnt++;
        end
        check(name, 8'(cnt), 8'(SETTLE_CYC));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        // 1: reset values, enable, settle length
        repeat (3) tick();
        rst = 1'b1;
        chk_en = 1'b1;
        tick();
        rd("rst_ctrl", 2'd0, 8'h00);
        rd("rst_status", 2'd1, 8'h00);
        rd("rst_filt", 2'd2, 8'h00);
        check("rst_acenable", {7'd0, acenable}, 8'd0);
        wr(2'd0, 8'h01);
        tick();
        check("en_acenable", {7'd0, acenable}, 8'd1);
        count_settle("settle1_len");

        // 2: rising edge with N=0, falling edge ignored
        wr(2'd2, 8'h00);
        wr(2'd0, 8'h0F);
        acout = 1'b1;
        tick(); tick();
        check("rise_aco_e2", {7'd0, aco}, 8'd0);
        tick();
        check("rise_aco_e3", {7'd0, aco}, 8'd1);
        check("rise_irq_e3", {7'd0, irq}, 8'd1);
        acout = 1'b0;
        repeat (5) tick();
        check("fall_aco", {7'd0, aco}, 8'd0);
        rd("fall_status", 2'd1, 8'h06);

        // 4a: plain W1C
        wr(2'd1, 8'h02);
        rd("w1c_status", 2'd1, 8'h04);
        check("w1c_irq", {7'd0, irq}, 8'd0);

        // 3: glitch filter N=3
        wr(2'd2, 8'h03);
        acout = 1'b1;
        repeat (3) tick();
        acout = 1'b0;
        repeat (6) tick();
        rd("glitch_status", 2'd1, 8'h04);
        acout = 1'b1;
        repeat (5) tick();
        check("filt_aco_e5", {7'd0, aco}, 8'd0);
        tick();
        check("filt_aco_e6", {7'd0, aco}, 8'd1);
        rd("filt_status", 2'd1, 8'h07);

        // 4b: set and clear in the same cycle, toggle mode
        wr(2'd1, 8'h02);
        wr(2'd2, 8'h00);
        wr(2'd0, 8'h09);
        acout = 1'b0;
        tick(); tick();
        wr(2'd1, 8'h02);
        rd("race_status", 2'd1, 8'h06);
        check("race_irq", {7'd0, irq}, 8'd1);
        wr(2'd1, 8'h02);

        // 5: disable mid-settle, full re-settle, no edge on RUN entry
        wr(2'd0, 8'h08);
        tick();
        wr(2'd0, 8'h09);
        tick();
        repeat (5) tick();
        wr(2'd0, 8'h08);
        check("dis_acenable", {7'd0, acenable}, 8'd0);
        tick();
        rd("dis_status", 2'd1, 8'h00);
        acout = 1'b1;
        wr(2'd0, 8'h09);
        tick();
        check("reen_acenable", {7'd0, acenable}, 8'd1);
        count_settle("settle2_len");
        rd("reen_status", 2'd1, 8'h05);
        check("reen_irq", {7'd0, irq}, 8'd0);

        // 6: async reset between edges
        acout = 1'b0;
        repeat (4) tick();
        acout = 1'b1;
        repeat (4) tick();
        rd("pre_rst_status", 2'd1, 8'h07);
        check("pre_rst_irq", {7'd0, irq}, 8'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_irq", {7'd0, irq}, 8'd0);
        check("arst_aco", {7'd0, aco}, 8'd0);
        check("arst_acenable", {7'd0, acenable}, 8'd0);
        tick();
        rst = 1'b1;
        tick();
        rd("post_rst_ctrl", 2'd0, 8'h00);
        rd("post_rst_status", 2'd1, 8'h00);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ac_dig.md
Name: ac_dig

Overview:
- Digital controller that sits directly downstream of the analog comparator model. It drives that model's `acenable` and consumes its raw `acout`.
- Processing chain: synchronise `acout`, wait a settling period after enable, filter glitches, detect the selected edge, then set a sticky interrupt flag.
- Software controls it through a small byte-wide register interface: CTRL, STATUS and FILT.

Parameters:
- SETTLE_CYC, 16: cycles after enable before comparator output is trusted (1..255).
- FILT_W, 4: width of the filter-length field and of the filter counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- acout  input  1  raw comparator output from the analog stage, asynchronous to clk
- acenable  output  1  enable to the analog stage
- addr  input  2  register address: 0 = CTRL, 1 = STATUS, 2 = FILT, 3 = reserved
- wdata  input  8  write data
- we  input  1  write strobe, single cycle
- rdata  output  8  combinational read of the register at addr; reserved and unused bits read 0
- aco  output  1  filtered comparator value (mirrors STATUS[0])
- irq  output  1  interrupt request, equal to ACI & ACIE

Behaviour:
- Reset values (rst low, asynchronous):
  - acenable=0, aco=0, irq=0.
  - All registers 0; state OFF.
  - Synchroniser flops, filter counter and settle counter all 0.
- Registers:
  - CTRL: [0] ACEN, [2:1] ACIS edge select (00 toggle, 01 toggle, 10 falling, 11 rising), [3] ACIE; [7:4] are written but ignored.
  - STATUS: [0] ACO, read-only; [1] ACI, write-1-to-clear; [2] READY, read-only (1 in RUN).
  - FILT: [FILT_W-1:0] filter length N.
- Synchroniser: two flops, acout -> s1 -> s2; s2 is the only internal use of acout.
- State machine (acenable = ACEN in SETTLE and RUN, 0 in OFF):
  - OFF: settle counter held at 0. On ACEN=1, next state is SETTLE and the counter loads SETTLE_CYC-1.
  - SETTLE: counter decrements each cycle. At 0 go to RUN. On entry to RUN, aco is loaded with s2 and the filter counter is cleared; no edge is reported for this load.
  - RUN: filtering and edge detection are active.
  - ACEN=0 in SETTLE or RUN returns to OFF next cycle. aco holds its value; the ACI flag is kept.
  - Re-enabling always performs a full settle again.
- Filter (RUN only):
  - If s2==aco, the filter counter is cleared.
  - If s2!=aco and counter==N, then aco<=s2 and the counter is cleared.
  - Otherwise the counter increments.
  - So aco changes only after s2 has differed for N+1 consecutive cycles.
  - A change to FILT mid-count takes effect on the next compare; the counter is not cleared.
- Latency: an acout change held stable is captured at edge 1 into s1 and edge 2 into s2. aco and ACI update at edge 3+N.
- Edge detect:
  - Evaluated on the cycle aco updates, using the old and new aco values.
  - Rising = 0->1; falling = 1->0; toggle = either.
  - A qualifying edge sets ACI on that same edge.
- ACI clear: a write to STATUS with wdata[1]=1 clears ACI. If set and clear occur in the same cycle, set wins.
- Interrupt: irq is combinational, ACI & ACIE. Setting ACIE with ACI already 1 raises irq immediately.
- Writes to read-only bits and to addr 3 have no effect.
- Reset mid-operation: all state returns to reset values immediately, with no settle and no flag.

Decomposition:
- Shared package ac_pkg:
  - Register address constants AC_CTRL=0, AC_STATUS=1, AC_FILT=2.
  - Enum ac_state_t {AC_OFF, AC_SETTLE, AC_RUN}.
  - Enum ac_isel_t for ACIS.
  - Bit-position constants for CTRL and STATUS fields.
- One sub-module: ac_filt, containing the synchroniser, filter counter and aco register, with ports clk, rst, run, load, n, din, dout, upd.
- The FSM, register file and edge detect stay in ac_dig.

Test Plan:
1. Reset then enable: pulse rst low; read all registers -> 0, acenable=0. Write CTRL=0x01 -> acenable=1 next cycle; STATUS[2]=0 for SETTLE_CYC (16) cycles, then 1.
2. Rising edge, N=0: ACIS=11, ACIE=1, RUN, acout=0. Raise acout -> aco=1 and irq=1 at the 3rd clk edge after the change; falling edge later -> ACI unchanged.
3. Glitch filter, N=3: in RUN with aco=0, acout high for 3 cycles -> aco stays 0, ACI=0. acout high for 4+ cycles -> aco=1 at edge 6.
4. W1C race: ACI=1; write STATUS=0x02 -> ACI=0, irq=0. Write STATUS=0x02 in the same cycle as a qualifying edge -> ACI stays 1.
5. Disable mid-SETTLE: clear ACEN after 5 settle cycles -> OFF, acenable=0, READY=0. Re-enable -> full 16-cycle settle; no edge reported when entering RUN, even if acout=1.
6. Async reset in RUN: ACI=1 and aco=1, assert rst between edges -> irq, aco and acenable drop to 0 immediately, without waiting for a clock edge.
